// File: rtl/scan_sel_gen.sv
// Digit-scan sequencer feeding a 2-to-4 decoder.
// Walks enabled digits with a dwell window and a blanking gap.
module scan_sel_gen #(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         mask,
  output logic               en,
  output logic [1:0]         a,
  output logic               frame_done
);

  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] BLAST =
    BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } state_t;

  state_t             st, st_n;
  logic [DWELL_W-1:0] dcnt, dcnt_n;
  logic [DWELL_W-1:0] dq, dq_n;
  logic [BW-1:0]      bcnt, bcnt_n;
  logic               pend, pend_n;
  logic               en_n, fd_n, adv;
  logic [1:0]         a_n, first, nxt;

  // first: search includes a itself; nxt: search starts above a
  always_comb begin
    first = a;
    nxt   = a;
    for (int i = 3; i >= 0; i--) begin
      if (mask[a + 2'(i)])
        first = a + 2'(i);
      if (mask[a + 2'(i + 1)])
        nxt = a + 2'(i + 1);
    end
  end

  always_comb begin
    st_n   = st;
    a_n    = a;
    dcnt_n = dcnt;
    bcnt_n = bcnt;
    dq_n   = dq;
    pend_n = pend;
    fd_n   = 1'b0;
    adv    = 1'b0;
    unique case (st)
      IDLE: begin
        if (mask != 4'd0 && (run || step)) begin
          st_n   = SHOW;
          a_n    = first;
          dq_n   = dwell;
          dcnt_n = '0;
          pend_n = !run;
        end
      end
      SHOW: begin
        if (dcnt == dq) begin
          if (BLANK_CYCLES == 0) begin
            adv = 1'b1;
          end else begin
            st_n   = BLANK;
            bcnt_n = '0;
          end
        end else begin
          dcnt_n = dcnt + DWELL_W'(1);
        end
      end
      BLANK: begin
        if (bcnt == BLAST)
          adv = 1'b1;
        else
          bcnt_n = bcnt + BW'(1);
      end
      default: st_n = IDLE;
    endcase
    if (adv) begin
      if (mask == 4'd0) begin
        st_n   = IDLE;
        pend_n = 1'b0;
      end else begin
        fd_n = (nxt <= a);
        a_n  = nxt;
        if (run && !pend) begin
          st_n   = SHOW;
          dq_n   = dwell;
          dcnt_n = '0;
        end else begin
          st_n   = IDLE;
          pend_n = 1'b0;
        end
      end
    end
    en_n = (st_n == SHOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      a          <= 2'd0;
      en         <= 1'b0;
      frame_done <= 1'b0;
      dcnt       <= '0;
      bcnt       <= '0;
      dq         <= '0;
      pend       <= 1'b0;
    end else begin
      st         <= st_n;
      a          <= a_n;
      en         <= en_n;
      frame_done <= fd_n;
      dcnt       <= dcnt_n;
      bcnt       <= bcnt_n;
      dq         <= dq_n;
      pend       <= pend_n;
    end
  end

endmodule

// File: tb/tb_scan_sel_gen.sv
// Bench for scan_sel_gen: queue-based digit-window model
// plus directed literal checks.
module tb_scan_sel_gen;

  localparam int DW = 8;
  localparam int BC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run, step;
  logic [DW-1:0] dwell;
  logic [3:0]    mask;
  logic          en, frame_done;
  logic [1:0]    a;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  scan_sel_gen #(.DWELL_W(DW), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step),
    .dwell(dwell), .mask(mask), .en(en), .a(a),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: each shown digit is a fixed list of future output cycles.
  // Entry format {en, fd, a}.
  logic [3:0] q[$];
  logic [3:0] cur;
  int         m_a;
  bit         busy, pend;

  function automatic int next_idx(input int base, input logic [3:0] m,
                                  input int from);
    for (int k = from; k < from + 4; k++)
      if (m[(base + k) % 4]) return (base + k) % 4;
    return base;
  endfunction

  task automatic start_digit(input bit fd);
    q.delete();
    for (int i = 0; i <= int'(dwell); i++)
      q.push_back({1'b1, (i == 0) ? fd : 1'b0, 2'(m_a)});
    for (int i = 0; i < BC; i++)
      q.push_back({1'b0, 1'b0, 2'(m_a)});
    cur  = q.pop_front();
    busy = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cur  = 4'd0;
      m_a  = 0;
      busy = 1'b0;
      pend = 1'b0;
    end else if (q.size() != 0) begin
      cur = q.pop_front();
    end else if (busy) begin
      if (mask == 4'd0) begin
        busy = 1'b0;
        pend = 1'b0;
        cur  = {1'b0, 1'b0, 2'(m_a)};
      end else begin
        int n;
        bit fd;
        n   = next_idx(m_a, mask, 1);
        fd  = (n <= m_a);
        m_a = n;
        if (run && !pend) begin
          start_digit(fd);
        end else begin
          pend = 1'b0;
          busy = 1'b0;
          cur  = {1'b0, fd, 2'(m_a)};
        end
      end
    end else if (mask != 4'd0 && (run || step)) begin
      m_a  = next_idx(m_a, mask, 0);
      pend = !run;
      start_digit(1'b0);
    end else begin
      cur = {1'b0, 1'b0, 2'(m_a)};
    end
  end

  always @(negedge clk) begin
    chk("model_en", int'(en), int'(cur[3]));
    chk("model_fd", int'(frame_done), int'(cur[2]));
    chk("model_a", int'(a), int'(cur[1:0]));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fd(input string nm, output int at);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_done && k < 300);
    if (!frame_done) chk({nm, "_timeout"}, 0, 1);
    at = cyc;
  endtask

  task automatic wait_show(input string nm, input int idx);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(en && int'(a) == idx) && k < 300);
    if (!(en && int'(a) == idx)) chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    int t0, t1, t2, cnt, a0;
    rst_n = 1'b0;
    run   = 1'b1;
    step  = 1'b0;
    dwell = 8'd3;
    mask  = 4'b1111;
    tick(3);
    chk("rst_en", int'(en), 0);
    chk("rst_a", int'(a), 0);
    chk("rst_fd", int'(frame_done), 0);
    rst_n = 1'b1;
    tick(1);
    chk("first_en", int'(en), 1);
    chk("first_a", int'(a), 0);

    // full scan: 4 digits x (4 + 2) cycles
    wait_fd("scan1", t0);
    chk("scan_fd_a", int'(a), 0);
    wait_fd("scan2", t1);
    chk("scan_period", t1 - t0, 24);

    dwell = 8'd0;
    mask  = 4'b0101;
    wait_fd("m5a", t0);
    wait_fd("m5b", t0);
    wait_fd("m5c", t1);
    chk("m5_period", t1 - t0, 6);
    chk("m5_fd_a", int'(a), 0);

    mask = 4'b1000;
    wait_fd("m8a", t0);
    wait_fd("m8b", t1);
    wait_fd("m8c", t2);
    chk("m8_period", t2 - t1, 3);
    chk("m8_a", int'(a), 3);

    // run drops two cycles into the digit-1 window
    dwell = 8'd5;
    mask  = 4'b1111;
    wait_fd("rd_fd", t0);
    wait_show("rd_show1", 1);
    tick(1);
    run = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (en) cnt++;
    end
    chk("rd_tail_en", cnt, 4);
    chk("rd_idle_en", int'(en), 0);
    chk("rd_idle_a", int'(a), 2);
    run = 1'b1;
    tick(1);
    chk("rd_resume_en", int'(en), 1);
    chk("rd_resume_a", int'(a), 2);
    run = 1'b0;
    tick(20);

    // single step with a stray step during the shown digit
    dwell = 8'd1;
    step  = 1'b1;
    tick(1);
    step = 1'b0;
    cnt  = 0;
    for (int i = 0; i < 10; i++) begin
      if (en) cnt++;
      if (i == 0) chk("step_a", int'(a), 3);
      step = (i == 0);
      @(negedge clk);
    end
    step = 1'b0;
    chk("step_en_cycles", cnt, 2);
    chk("step_after_a", int'(a), 0);

    // asynchronous reset while digit 2 is shown
    run   = 1'b1;
    dwell = 8'd5;
    wait_show("ar_show2", 2);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_en", int'(en), 0);
    chk("ar_a", int'(a), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // mask cleared mid-digit: digit completes, no wrap pulse
    wait_show("mc_show", 0);
    tick(2);
    a0   = int'(a);
    mask = 4'b0000;
    cnt  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_done) cnt++;
    end
    chk("mc_fd", cnt, 0);
    chk("mc_a", int'(a), a0);
    chk("mc_en", int'(en), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
